// File: rtl/uart_rx_framer_if.sv
// Byte-stream side of the UART receive framer: serial line in, held byte and status pulses out.
interface uart_rx_framer_if;
    logic       rx;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rx, data_ready,
        input  data_out, data_valid, frame_err, parity_err, overrun, busy
    );

    modport slave (
        input  rx, data_ready,
        output data_out, data_valid, frame_err, parity_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_framer.sv
// 8-bit UART receiver with majority-vote sampling, glitch rejection and a one-byte holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_framer #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 19200
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_framer_if.slave   bus
);
    localparam int          DIV    = CLK_FREQ / BAUD_RATE;
    localparam int          HALF   = (DIV - 1) / 2;
    localparam logic [11:0] DIV_M1 = 12'(DIV - 1);
    localparam logic [11:0] HALF_C = 12'(HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_sync_q;
    logic [2:0]  hist_q;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        parity_err_q, parity_err_d;
    logic        overrun_q, overrun_d;
    logic        maj, par_bad, byte_ok;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
`endif

    // Vote over the last three synchronized samples to reject single-cycle noise.
    assign maj = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q & ~bus.data_ready;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        par_bad      = 1'b0;
        byte_ok      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        par_bad      = ^{shift_q, par_q};
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_sync_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d   = '0;
                    state_d = maj ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = maj;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d   = '0;
                    par_d   = maj;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d = '0;
                    if (!maj) begin
                        frame_err_d  = 1'b1;
                        parity_err_d = par_bad;
                        state_d      = S_BREAK;
                    end else begin
                        parity_err_d = par_bad;
                        byte_ok      = ~par_bad;
                        state_d      = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_BREAK: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A pending byte can be replaced only if the consumer takes it this same cycle.
        if (byte_ok) begin
            if (!data_valid_q || bus.data_ready) begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            hist_q       <= 3'b111;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= bus.rx;
            rx_sync_q    <= rx_meta_q;
            hist_q       <= {hist_q[1:0], rx_sync_q};
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: random frames, expected events queued at issue, monitor compares.
module tb_uart_rx_framer;
    localparam int DIV = 10;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 108;
`else
    localparam int LAT = 98;
`endif
    localparam int EV_VALID = 0;
    localparam int EV_FERR  = 1;
    localparam int EV_PERR  = 2;
    localparam int EV_OVR   = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_framer_if bus();

    uart_rx_framer #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    bit  model_full = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(int k, logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(int k, logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected no event", k, d);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (k == EV_VALID && e.kind == EV_VALID) chk("data_out", d, e.data);
        end
    endtask

    // Reference: a frame is good when stop is high (and parity even); a good byte is
    // delivered if the holding register is free or being consumed, else it overruns.
    task automatic send_frame(logic [7:0] b, bit stop_ok, bit par_ok, int hold_low);
        bit good;
        good = stop_ok;
`ifdef UART_RX_PARITY_EN
        good = stop_ok && par_ok;
`endif
        if (!stop_ok) push(EV_FERR, 8'h00);
`ifdef UART_RX_PARITY_EN
        if (!par_ok) push(EV_PERR, 8'h00);
`endif
        if (good) begin
            if (!model_full || bus.data_ready) begin
                push(EV_VALID, b);
                model_full = !bus.data_ready;
            end else begin
                push(EV_OVR, 8'h00);
            end
        end
        start_cyc = cyc;
        bus.rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(DIV);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = par_ok ? ^b : ~^b;
        tick(DIV);
`endif
        bus.rx = stop_ok;
        tick(DIV);
        if (!stop_ok) begin
            tick(hold_low);
            chk("busy_in_break", bus.busy, 1);
            bus.rx = 1'b1;
            tick(4);
            chk("busy_after_break", bus.busy, 0);
        end
        bus.rx = 1'b1;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_data_out"},   bus.data_out, 0);
        chk({tag, "_data_valid"}, bus.data_valid, 0);
        chk({tag, "_frame_err"},  bus.frame_err, 0);
        chk({tag, "_parity_err"}, bus.parity_err, 0);
        chk({tag, "_overrun"},    bus.overrun, 0);
        chk({tag, "_busy"},       bus.busy, 0);
    endtask

    // Monitor: samples on the falling edge, independent of the stimulus thread.
    logic       pv = 1'b0;
    logic       pready = 1'b0;
    logic [7:0] pout = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (bus.data_valid && (!pv || pready)) begin
                check_ev(EV_VALID, bus.data_out);
                checks++;
                if ((cyc - start_cyc) < LAT - 3 || (cyc - start_cyc) > LAT + 3) begin
                    errors++;
                    $display("FAIL valid_latency: got %0d expected %0d +-3", cyc - start_cyc, LAT);
                end
            end
            if (pv && !pready) begin
                chk("hold_valid", bus.data_valid, 1);
                chk("hold_data", bus.data_out, pout);
            end
            if (bus.frame_err)  check_ev(EV_FERR, 8'h00);
            if (bus.parity_err) check_ev(EV_PERR, 8'h00);
            if (bus.overrun)    check_ev(EV_OVR, 8'h00);
            pv     = bus.data_valid;
            pout   = bus.data_out;
            pready = bus.data_ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bus.rx = 1'b1;
        bus.data_ready = 1'b1;
        rst = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(5);

        send_frame(8'hA5, 1, 1, 0);
        tick(20);

        // Short low pulse must be rejected as a glitch.
        bus.rx = 1'b0;
        tick(3);
        bus.rx = 1'b1;
        tick(30);
        chk("glitch_idle", bus.busy, 0);

        send_frame(8'h3C, 0, 1, 20);
        tick(20);

        bus.data_ready = 1'b0;
        send_frame(8'h11, 1, 1, 0);
        tick(5);
        send_frame(8'h22, 1, 1, 0);
        tick(5);
        chk("ovr_data_held", bus.data_out, 8'h11);
        chk("ovr_valid_held", bus.data_valid, 1);
        bus.data_ready = 1'b1;
        model_full = 0;
        tick(1);
        chk("consume_clears_valid", bus.data_valid, 0);
        chk("consume_keeps_data", bus.data_out, 8'h11);
        tick(10);

        // Abandon a frame with reset partway through data bit 4.
        b = 8'hC3;
        bus.rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            bus.rx = b[i];
            tick(DIV);
        end
        bus.rx = b[4];
        tick(5);
        chk("busy_mid_data", bus.busy, 1);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("midreset");
        rst = 1'b0;
        bus.rx = 1'b1;
        model_full = 0;
        tick(20);
        send_frame(8'h5A, 1, 1, 0);
        tick(20);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1, 0, 0);
        tick(20);
        send_frame(8'h07, 1, 1, 0);
        tick(20);
`endif

        for (int n = 0; n < 24; n++) begin
            bit rdy;
            rdy = ($urandom_range(0, 2) != 0);
            bus.data_ready = rdy;
            if (rdy) model_full = 0;
            send_frame(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                       $urandom_range(0, 15));
            tick(2 + $urandom_range(0, 6));
        end
        bus.data_ready = 1'b1;
        tick(200);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
